// File: rtl/edge_result_collector.sv
// Captures one processed frame from the edge detector into a RAM, then serves it over an Avalon-MM read port.
// Read latency 1 cycle; waitrequest stalls host reads while a capture is armed or in progress, and the pixel stream is never stalled.
module edge_result_collector #(
    parameter int IMG_X_SIZE = 564,
    parameter int IMG_Y_SIZE = 1221,
    parameter int ADDR_W     = 20
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              arm_i,
    input  logic              dataAvailable_i,
    input  logic              valid_i,
    input  logic [7:0]        pixel_i,
    input  logic [ADDR_W-1:0] avs_address_i,
    input  logic              avs_read_i,
    output logic              avs_waitrequest_o,
    output logic [7:0]        avs_readdata_o,
    output logic              avs_readdatavalid_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              overflow_o,
    output logic [ADDR_W-1:0] count_o
);

    localparam int unsigned OUT_PIXELS = (IMG_X_SIZE - 2) * (IMG_Y_SIZE - 2);
    localparam int          MEM_AW     = (OUT_PIXELS > 1) ? $clog2(OUT_PIXELS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_AVAIL,
        CAPTURE,
        DONE
    } state_t;

    state_t     state;
    logic [7:0] mem [OUT_PIXELS];
    logic       we;
    logic       rd_acc;
    logic       addr_in_range;
    logic       last_pixel;

    assign busy_o            = (state == WAIT_AVAIL) || (state == CAPTURE);
    assign done_o            = (state == DONE);
    assign avs_waitrequest_o = busy_o;

    // arm_i wins over a coincident pixel, so a re-arm never writes
    assign we = valid_i && !arm_i &&
                ((state == CAPTURE) || ((state == WAIT_AVAIL) && dataAvailable_i));

    assign rd_acc        = avs_read_i && !busy_o;
    assign addr_in_range = 32'(avs_address_i) < OUT_PIXELS;
    assign last_pixel    = 32'(count_o) == (OUT_PIXELS - 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else if (arm_i) begin
            state      <= WAIT_AVAIL;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            case (state)
                WAIT_AVAIL: if (dataAvailable_i) state <= CAPTURE;
                DONE:       if (valid_i) overflow_o <= 1'b1;
                default:    ;
            endcase
            if (we) begin
                count_o <= count_o + ADDR_W'(1);
                if (last_pixel) state <= DONE;
            end
        end
    end

    // Buffer is deliberately not reset; reset only gates further writes
    always_ff @(posedge clk_i) begin
        if (we) mem[count_o[MEM_AW-1:0]] <= pixel_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            avs_readdatavalid_o <= 1'b0;
            avs_readdata_o      <= 8'h00;
        end else begin
            avs_readdatavalid_o <= rd_acc;
            if (rd_acc) begin
                avs_readdata_o <= addr_in_range ? mem[avs_address_i[MEM_AW-1:0]] : 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_edge_result_collector.sv
`timescale 1ns/1ps
module tb_edge_result_collector;

    localparam int X = 5;
    localparam int Y = 4;
    localparam int AW = 3;
    localparam int NPIX = (X - 2) * (Y - 2);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          arm = 1'b0;
    logic          dav = 1'b0;
    logic          vld = 1'b0;
    logic [7:0]    pix = 8'h00;
    logic [AW-1:0] addr = '0;
    logic          rd = 1'b0;
    logic          waitreq;
    logic [7:0]    rdata;
    logic          rvld;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [AW-1:0] count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    edge_result_collector #(
        .IMG_X_SIZE(X),
        .IMG_Y_SIZE(Y),
        .ADDR_W    (AW)
    ) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .arm_i              (arm),
        .dataAvailable_i    (dav),
        .valid_i            (vld),
        .pixel_i            (pix),
        .avs_address_i      (addr),
        .avs_read_i         (rd),
        .avs_waitrequest_o  (waitreq),
        .avs_readdata_o     (rdata),
        .avs_readdatavalid_o(rvld),
        .busy_o             (busy),
        .done_o             (done),
        .overflow_o         (ovf),
        .count_o            (count)
    );

    always #5 clk = ~clk;

    // Reference model: phase flags, a pixel counter and a shadow frame buffer
    bit       m_waiting, m_capturing, m_done, m_ovf, m_rvld, m_rknown;
    int       m_cnt;
    bit [7:0] m_rdata;
    bit [7:0] m_mem [NPIX];
    bit       m_written [NPIX];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_waiting   <= 1'b0;
            m_capturing <= 1'b0;
            m_done      <= 1'b0;
            m_ovf       <= 1'b0;
            m_cnt       <= 0;
            m_rvld      <= 1'b0;
            m_rdata     <= 8'h00;
            m_rknown    <= 1'b1;
        end else begin
            m_rvld <= rd && !(m_waiting || m_capturing);
            if (rd && !(m_waiting || m_capturing)) begin
                if (int'(addr) < NPIX) begin
                    m_rdata  <= m_mem[int'(addr)];
                    m_rknown <= m_written[int'(addr)];
                end else begin
                    m_rdata  <= 8'h00;
                    m_rknown <= 1'b1;
                end
            end
            if (arm) begin
                m_waiting   <= 1'b1;
                m_capturing <= 1'b0;
                m_done      <= 1'b0;
                m_cnt       <= 0;
                m_ovf       <= 1'b0;
            end else if (m_done) begin
                if (vld) m_ovf <= 1'b1;
            end else if (m_capturing || (m_waiting && dav)) begin
                m_waiting   <= 1'b0;
                m_capturing <= 1'b1;
                if (vld) begin
                    m_mem[m_cnt]     <= pix;
                    m_written[m_cnt] <= 1'b1;
                    m_cnt            <= m_cnt + 1;
                    if (m_cnt + 1 == NPIX) begin
                        m_done      <= 1'b1;
                        m_capturing <= 1'b0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", int'(busy), int'(m_waiting || m_capturing));
            chk("waitrequest", int'(waitreq), int'(m_waiting || m_capturing));
            chk("done", int'(done), int'(m_done));
            chk("overflow", int'(ovf), int'(m_ovf));
            chk("count", int'(count), m_cnt);
            chk("readdatavalid", int'(rvld), int'(m_rvld));
            if (m_rknown) chk("readdata", int'(rdata), int'(m_rdata));
        end
    end

    // Drive one cycle of inputs; returns 2ns after the edge that consumed them
    task automatic cyc(input bit a, input bit d, input bit v, input logic [7:0] p,
                       input bit r, input logic [AW-1:0] ad);
        arm  = a;
        dav  = d;
        vld  = v;
        pix  = p;
        rd   = r;
        addr = ad;
        @(posedge clk);
        #2;
    endtask

    task automatic frame(input logic [7:0] base);
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < NPIX; i++) cyc(0, 1, 1, base + 8'(i), 0, 0);
    endtask

    task automatic read_lit(input logic [AW-1:0] ad, input logic [7:0] exp);
        cyc(0, 0, 0, 8'h00, 1, ad);
        chk("lit_rvld", int'(rvld), 1);
        chk("lit_rdata", int'(rdata), int'(exp));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmp_en = 1'b1;
        #12;
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Plain full frame then back-to-back readout
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < NPIX; i++) begin
            cyc(0, 1, 1, 8'h10 + 8'(i), 0, 0);
            if (i == 2) chk("t1_busy", int'(busy), 1);
        end
        chk("t1_done", int'(done), 1);
        chk("t1_count", int'(count), 6);
        for (int i = 0; i < NPIX; i++) read_lit(AW'(i), 8'h10 + 8'(i));
        cyc(0, 0, 0, 8'h00, 0, 0);
        chk("t1_rvld_idle", int'(rvld), 0);

        // Pre-availability pixels and gaps
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 1, 8'h55, 0, 0);
        cyc(0, 0, 1, 8'h56, 0, 0);
        chk("t2_count_pre", int'(count), 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2) == 0, 8'hA0 + 8'(i), 0, 0);
        chk("t2_count", int'(count), 2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 8'hB0 + 8'(i), 0, 0);
        read_lit(0, 8'hA0);
        read_lit(1, 8'hA2);
        read_lit(2, 8'hB0);

        // Read stalled during capture, accepted once done
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'hC0 + 8'(i), 0, 0);
        for (int i = 3; i < NPIX; i++) begin
            cyc(0, 1, 1, 8'hC0 + 8'(i), 1, 2);
            chk("t3_rvld_stalled", int'(rvld), 0);
        end
        chk("t3_waitreq_done", int'(waitreq), 0);
        read_lit(2, 8'hC2);

        // Overflow in DONE, then re-arm clears it
        cyc(0, 1, 1, 8'hFF, 0, 0);
        chk("t4_overflow", int'(ovf), 1);
        for (int i = 0; i < NPIX; i++) read_lit(AW'(i), 8'hC0 + 8'(i));
        cyc(1, 0, 0, 8'h00, 0, 0);
        chk("t4_ovf_clear", int'(ovf), 0);
        chk("t4_count_clear", int'(count), 0);

        // Out-of-range address reads zero
        for (int i = 0; i < NPIX; i++) cyc(0, 1, 1, 8'hD0 + 8'(i), 0, 0);
        read_lit(7, 8'h00);
        read_lit(6, 8'h00);

        // Asynchronous reset mid-capture
        cyc(1, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 8'hE0 + 8'(i), 0, 0);
        rst_n = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_count", int'(count), 0);
        chk("t6_waitreq", int'(waitreq), 0);
        cyc(0, 1, 1, 8'hEE, 0, 0);
        rst_n = 1'b1;
        frame(8'hF0);
        chk("t6_done", int'(done), 1);
        for (int i = 0; i < NPIX; i++) read_lit(AW'(i), 8'hF0 + 8'(i));

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 1) == 1, 8'($urandom), $urandom_range(0, 1) == 1,
                AW'($urandom_range(0, 7)));
        end
        cyc(0, 0, 0, 8'h00, 0, 0);

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/edge_result_collector.md
Name: edge_result_collector

Overview:
Sink-side companion to EdgeDetector. Sits on the detector's output stream (dataAvailable/valid/ProcessedImagePixel) and captures one full processed frame of (IMG_X_SIZE-2)*(IMG_Y_SIZE-2) pixels into an internal buffer. The frame is then served to the host through an Avalon-MM slave read port. This replaces the bench-side OUTPUT array capture with synthesizable hardware.

Parameters:
IMG_X_SIZE, 564, input image width; must match EdgeDetector.
IMG_Y_SIZE, 1221, input image height; must match EdgeDetector.
ADDR_W, 20, read address width; must satisfy 2^ADDR_W >= OUT_PIXELS.
Derived localparam OUT_PIXELS = (IMG_X_SIZE-2)*(IMG_Y_SIZE-2).

Ports:
clk_i  in  1  single clock, all logic on rising edge.
rst_ni  in  1  asynchronous, active-low reset.
arm_i  in  1  one-cycle pulse that starts or restarts capture of one frame.
dataAvailable_i  in  1  from EdgeDetector dataAvailable_o.
valid_i  in  1  from EdgeDetector valid_o; qualifies pixel_i.
pixel_i  in  8  from EdgeDetector ProcessedImagePixel_o.
avs_address_i  in  ADDR_W  pixel index to read.
avs_read_i  in  1  Avalon read request.
avs_waitrequest_o  out  1  read stall.
avs_readdata_o  out  8  read data.
avs_readdatavalid_o  out  1  read data qualifier.
busy_o  out  1  high in WAIT_AVAIL or CAPTURE.
done_o  out  1  high in DONE.
overflow_o  out  1  sticky: a pixel arrived while in DONE.
count_o  out  ADDR_W  number of pixels stored so far.

Behaviour:
- Reset (rst_ni=0, async): state IDLE; count_o=0; all outputs 0. Buffer contents are not cleared.
- Reset mid-capture: aborts immediately; no further writes occur.
- States: IDLE, WAIT_AVAIL, CAPTURE, DONE.
- arm_i in any state: go to WAIT_AVAIL next cycle, clearing count_o and overflow_o. arm_i has priority over every other event in that cycle.
- Write enable we = valid_i && (state==CAPTURE || (state==WAIT_AVAIL && dataAvailable_i)).
- When we is high: mem[count] <= pixel_i and count <= count+1.
- valid_i in IDLE, or in WAIT_AVAIL with dataAvailable_i=0: ignored.
- WAIT_AVAIL -> CAPTURE when dataAvailable_i=1, whether or not valid_i is high.
- In CAPTURE, valid_i=0 cycles are gaps: no write, count holds. dataAvailable_i dropping does not leave CAPTURE.
- When the write at count==OUT_PIXELS-1 occurs: go to DONE next cycle, with count_o=OUT_PIXELS and done_o=1 on that same edge.
- DONE: valid_i=1 sets overflow_o; the pixel is dropped and the buffer is unchanged. DONE holds until arm_i or reset.
- avs_waitrequest_o = busy_o (combinational from state).
- A read is accepted when avs_read_i && !avs_waitrequest_o. Reads are accepted in IDLE and DONE.
- Fixed read latency 1: avs_readdatavalid_o=1 the cycle after acceptance; otherwise 0.
- Read data: avs_readdata_o = mem[avs_address_i] if avs_address_i < OUT_PIXELS, else 0x00 (readdatavalid still asserted).
- avs_readdata_o holds its last value when readdatavalid is 0.
- Back-to-back reads are allowed, one per cycle.
- Buffer is a single-write, single-read synchronous RAM of OUT_PIXELS x 8.

Test Plan:
(All with IMG_X_SIZE=5, IMG_Y_SIZE=4, ADDR_W=3, OUT_PIXELS=6.)
1. Reset, pulse arm_i, raise dataAvailable_i, drive valid pixels 0x10..0x15 on consecutive cycles -> busy_o=1 during capture; done_o=1 and count_o=6 after the 6th edge; reads of addr 0..5 return 0x10..0x15, readdatavalid 1 cycle after each.
2. During capture, drive valid_i=1 with dataAvailable_i=0 before availability, then pattern valid 1,0,1,0 with pixels 0xA0..0xA3 -> pre-availability pixels not stored; only 0xA0 and 0xA2 stored at addr 0,1; count_o=2.
3. Assert avs_read_i addr 2 while in CAPTURE -> avs_waitrequest_o=1 and no readdatavalid until DONE; then accepted, returns the stored value 1 cycle later.
4. After DONE, drive one extra valid pixel 0xFF -> overflow_o=1; mem[0..5] unchanged; arm_i then clears overflow_o and count_o.
5. Read addr 7 in DONE -> avs_readdata_o=0x00 with readdatavalid=1.
6. Pull rst_ni low asynchronously after 3 of 6 pixels -> same cycle busy_o=0, count_o=0, waitrequest=0; re-arm plus a full 6-pixel frame -> done_o=1 with correct data.
